// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the multi-cycle MUL path
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MUL_BITS_DEFAULT = 8;

    // Booth pair {Q[0], q_m1} values that touch the accumulator
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_multiplier_if.sv
// rtl/booth_multiplier_if.sv - request/result bundle between ALU control and the Booth multiplier
interface booth_multiplier_if
    import alu_pkg::*;
#(
    parameter int BITS = MUL_BITS_DEFAULT
);
    logic                start_i;
    logic [BITS-1:0]     multiplicand_i;
    logic [BITS-1:0]     multiplier_i;
    logic                busy_o;
    logic                done_o;
    logic [2*BITS-1:0]   product_o;
    logic                flag_z_o;
    logic                flag_n_o;

    modport master (
        output start_i, multiplicand_i, multiplier_i,
        input  busy_o, done_o, product_o, flag_z_o, flag_n_o
    );

    modport slave (
        input  start_i, multiplicand_i, multiplier_i,
        output busy_o, done_o, product_o, flag_z_o, flag_n_o
    );
endinterface

// File: rtl/adder_substractor.sv
// rtl/adder_substractor.sv - ALU two's-complement adder/subtractor with signed overflow
module adder_substractor #(
    parameter int BITS = 9
) (
    input  logic [BITS-1:0] bus_a_i,
    input  logic [BITS-1:0] bus_b_i,
    input  logic            select_i,
    output logic [BITS-1:0] sum_o,
    output logic            overflow_o
);
    logic [BITS-1:0] b_eff;

    // select_i=1 computes a - b as a + ~b + 1
    assign b_eff      = select_i ? ~bus_b_i : bus_b_i;
    assign sum_o      = bus_a_i + b_eff + {{(BITS-1){1'b0}}, select_i};
    assign overflow_o = (bus_a_i[BITS-1] == b_eff[BITS-1]) && (sum_o[BITS-1] != bus_a_i[BITS-1]);
endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - iterative signed radix-2 Booth multiplier, one product per BITS+1 cycles
module booth_multiplier
    import alu_pkg::*;
#(
    parameter int BITS = MUL_BITS_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    booth_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(BITS + 1);

    mult_state_t        state_r;
    logic [BITS:0]      a_r;
    logic [BITS-1:0]    q_r;
    logic               q_m1_r;
    logic [BITS:0]      m_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               busy_r;
    logic               done_r;
    logic [2*BITS-1:0]  product_r;
    logic               flag_z_r;
    logic               flag_n_r;

    logic [1:0]         booth_pair;
    logic [BITS:0]      sum;
    logic               addsub_ovf;
    logic [BITS:0]      a_upd;
    logic [BITS:0]      a_nxt;
    logic [BITS-1:0]    q_nxt;
    logic               q_m1_nxt;
    logic [2*BITS-1:0]  product_nxt;

    assign booth_pair = {q_r[0], q_m1_r};

    adder_substractor #(
        .BITS (BITS + 1)
    ) u_adder_substractor (
        .bus_a_i    (a_r),
        .bus_b_i    (m_r),
        .select_i   (booth_pair == BOOTH_SUB),
        .sum_o      (sum),
        .overflow_o (addsub_ovf)
    );

    assign a_upd = (booth_pair == BOOTH_ADD || booth_pair == BOOTH_SUB) ? sum : a_r;
    assign {a_nxt, q_nxt, q_m1_nxt} = {a_upd[BITS], a_upd, q_r};
    assign product_nxt = {a_nxt[BITS-1:0], q_nxt};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            a_r       <= '0;
            q_r       <= '0;
            q_m1_r    <= 1'b0;
            m_r       <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
            flag_z_r  <= 1'b1;
            flag_n_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r == CALC) begin
                a_r    <= a_nxt;
                q_r    <= q_nxt;
                q_m1_r <= q_m1_nxt;
                cnt_r  <= cnt_r - 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    state_r   <= DONE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    product_r <= product_nxt;
                    flag_z_r  <= (product_nxt == '0);
                    flag_n_r  <= product_nxt[2*BITS-1];
                end
            end else if (bus.start_i) begin
                // IDLE or DONE: accept a new request, back-to-back from DONE included
                state_r <= CALC;
                busy_r  <= 1'b1;
                a_r     <= '0;
                q_r     <= bus.multiplier_i;
                q_m1_r  <= 1'b0;
                m_r     <= {bus.multiplicand_i[BITS-1], bus.multiplicand_i};
                cnt_r   <= CNT_W'(BITS);
            end else begin
                state_r <= IDLE;
            end
        end
    end

    // The BITS+1 wide accumulator leaves headroom for M = -2^(BITS-1)
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_r == CALC && (booth_pair == BOOTH_ADD || booth_pair == BOOTH_SUB)) |-> !addsub_ovf);

    assign bus.busy_o    = busy_r;
    assign bus.done_o    = done_r;
    assign bus.product_o = product_r;
    assign bus.flag_z_o  = flag_z_r;
    assign bus.flag_n_o  = flag_n_r;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
module tb_booth_multiplier;
    localparam int BITS = 8;
    localparam int DONE_AT = BITS + 1;
    localparam int LIMIT = 40;

    typedef struct {
        logic [BITS-1:0]   m;
        logic [BITS-1:0]   q;
        logic [2*BITS-1:0] p;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    booth_multiplier_if #(.BITS(BITS)) bus_if ();

    booth_multiplier #(.BITS(BITS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [2*BITS-1:0] ref_mul(input logic [BITS-1:0] m, input logic [BITS-1:0] q);
        logic signed [2*BITS-1:0] sm;
        logic signed [2*BITS-1:0] sq;
        sm = $signed(m);
        sq = $signed(q);
        return sm * sq;
    endfunction

    // Drive a one-cycle start; returns at the first negedge after the accepting edge
    task automatic start_op(input logic [BITS-1:0] m, input logic [BITS-1:0] q);
        @(negedge clk);
        bus_if.start_i        = 1'b1;
        bus_if.multiplicand_i = m;
        bus_if.multiplier_i   = q;
        @(negedge clk);
        bus_if.start_i = 1'b0;
    endtask

    // n counts negedges after the accepting edge; stops on done or after LIMIT
    task automatic wait_done(input int n0, output int n_done, output int busy_cnt);
        int n;
        n = n0;
        busy_cnt = 0;
        while (!bus_if.done_o && n < LIMIT) begin
            busy_cnt += int'(bus_if.busy_o);
            @(negedge clk);
            n++;
        end
        n_done = n;
    endtask

    task automatic check_result(input string name, input logic [2*BITS-1:0] exp);
        check({name, " product"}, 32'(bus_if.product_o), 32'(exp));
        check({name, " flag_z"}, 32'(bus_if.flag_z_o), 32'(exp == '0));
        check({name, " flag_n"}, 32'(bus_if.flag_n_o), 32'(exp[2*BITS-1]));
    endtask

    task automatic run_vec(input string name, input logic [BITS-1:0] m, input logic [BITS-1:0] q,
                           input logic [2*BITS-1:0] exp);
        int n_done;
        int busy_cnt;
        start_op(m, q);
        wait_done(1, n_done, busy_cnt);
        check({name, " done latency"}, 32'(n_done), 32'(DONE_AT));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(BITS));
        check_result(name, exp);
        @(negedge clk);
        check({name, " single done"}, 32'(bus_if.done_o), 32'd0);
        check({name, " product hold"}, 32'(bus_if.product_o), 32'(exp));
    endtask

    initial begin
        vec_t vecs[$];
        int   n_done;
        int   busy_cnt;
        int   pulses;
        logic [BITS-1:0] rm;
        logic [BITS-1:0] rq;

        n_cmp = 0;
        n_bad = 0;
        vecs.push_back('{8'h03, 8'h05, 16'h000F});
        vecs.push_back('{8'hF9, 8'h06, 16'hFFD6});
        vecs.push_back('{8'h80, 8'h80, 16'h4000});
        vecs.push_back('{8'h80, 8'h7F, 16'hC080});
        vecs.push_back('{8'h00, 8'h55, 16'h0000});
        vecs.push_back('{8'h7F, 8'h7F, 16'h3F01});
        vecs.push_back('{8'hFF, 8'hFF, 16'h0001});
        vecs.push_back('{8'h7F, 8'h80, 16'hC080});

        rst_n = 1'b0;
        bus_if.start_i = 1'b0;
        bus_if.multiplicand_i = '0;
        bus_if.multiplier_i = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus_if.busy_o), 32'd0);
        check("reset done", 32'(bus_if.done_o), 32'd0);
        check("reset product", 32'(bus_if.product_o), 32'd0);
        check("reset flag_z", 32'(bus_if.flag_z_o), 32'd1);
        check("reset flag_n", 32'(bus_if.flag_n_o), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].p);

        for (int i = 0; i < 40; i++) begin
            rm = BITS'($urandom);
            rq = BITS'($urandom);
            run_vec($sformatf("rand %0h*%0h", rm, rq), rm, rq, ref_mul(rm, rq));
        end

        // Back-to-back: start asserted during the DONE cycle skips IDLE
        start_op(8'h00, 8'h55);
        wait_done(1, n_done, busy_cnt);
        check("b2b first latency", 32'(n_done), 32'(DONE_AT));
        check_result("b2b first", 16'h0000);
        bus_if.start_i = 1'b1;
        bus_if.multiplicand_i = 8'h02;
        bus_if.multiplier_i = 8'hFF;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        check("b2b no idle", 32'(bus_if.busy_o), 32'd1);
        wait_done(1, n_done, busy_cnt);
        check("b2b second latency", 32'(n_done), 32'(DONE_AT));
        check("b2b second busy", 32'(busy_cnt), 32'(BITS));
        check_result("b2b second", 16'hFFFE);

        // Start and operand changes during CALC are ignored
        start_op(8'h04, 8'h04);
        repeat (2) @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.multiplicand_i = 8'h09;
        bus_if.multiplier_i = 8'h09;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        wait_done(4, n_done, busy_cnt);
        check("ignore latency", 32'(n_done), 32'(DONE_AT));
        check_result("ignore", 16'h0010);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(bus_if.done_o);
        end
        check("ignore no extra done", 32'(pulses), 32'd0);

        // Reset mid-CALC aborts immediately with no done pulse
        start_op(8'h0A, 8'h0A);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus_if.busy_o), 32'd0);
        check("abort done", 32'(bus_if.done_o), 32'd0);
        check("abort product", 32'(bus_if.product_o), 32'd0);
        check("abort flag_z", 32'(bus_if.flag_z_o), 32'd1);
        check("abort flag_n", 32'(bus_if.flag_n_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(bus_if.done_o);
            if (i == 2) rst_n = 1'b1;
        end
        check("abort no done", 32'(pulses), 32'd0);
        run_vec("after reset", 8'h01, 8'hFF, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
